prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Writer side of the MCX program memory. It accepts a byte stream over a valid/ready handshake and parses it into framed program images. Each 46-bit instruction line is written into the writable program memory at addresses 0..N-1. While an image is loading, and until one loads cleanly, it holds the MCX core in reset through cpu_hold.

Parameters:
DEPTH, 16, number of program lines; address width is 4 bits and DEPTH must be at most 16.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT, 1000, maximum idle clk cycles between bytes inside a frame before abort.
HOLD_AT_RESET, 1, reset value of cpu_hold.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-high.
in_data  input  8  stream byte.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  loader accepts a byte this cycle; the byte transfers when in_valid && in_ready.
mem_we  output  1  one-cycle write strobe to program memory.
mem_addr  output  4  line address for the write.
mem_data  output  46  line: PC[45:42], cond[41:40], inst[39:36], arg1[35:24], arg2[23:12], arg3[11:0].
cpu_hold  output  1  high keeps the MCX core in reset; the top level inverts it into nrst.
busy  output  1  a frame is in progress (state is not IDLE).
done  output  1  one-cycle pulse when a frame completes with a good checksum.
err  output  1  one-cycle pulse when a frame is aborted.
err_code  output  2  valid only with err: 0 = bad count, 1 = checksum mismatch, 2 = reserved bits set, 3 = timeout.
lines_loaded  output  5  line count of the last good frame; 0 after reset.

Behaviour:
- Reset values: state = IDLE, in_ready = 1, mem_we = 0, mem_addr = 0, mem_data = 0, cpu_hold = HOLD_AT_RESET, busy = 0, done = 0, err = 0, err_code = 0, lines_loaded = 0. Reset mid-frame discards all partial state; lines already written stay in memory.
- Frame format: SYNC_BYTE, COUNT (1..DEPTH), COUNT x 6 line bytes (big-endian, byte0 first), CSUM.
- Line bytes: byte0[7:6] are reserved and must be 0. Bits {byte0[5:0], bytes1..5} form the 46-bit line.
- Checksum: CSUM must equal the XOR of all line bytes. SYNC and COUNT are excluded. A frame with no line bytes would have XOR 8'h00.
- in_ready is 1 in every state except the single WRITE cycle, where it is 0.
- States:
  - IDLE: a byte equal to SYNC_BYTE -> COUNT, and cpu_hold goes to 1 on the next cycle. Any other byte is consumed and ignored.
  - COUNT: byte 0 or byte > DEPTH -> err with code 0, back to IDLE. Otherwise latch N, clear the line index, byte index and running XOR, then -> DATA.
  - DATA: shift the byte into a 48-bit assembly register and XOR it into the running checksum. On byte index 0, if bits [7:6] != 0 -> err with code 2, back to IDLE, no write. After the 6th byte -> WRITE.
  - WRITE: one cycle. mem_we = 1, mem_addr = line index, mem_data = assembly[45:0]. Then increment the line index. Go to CSUM if the incremented index equals N, else back to DATA.
  - CSUM: match -> done pulse, lines_loaded = N, cpu_hold = 0 on the next cycle, back to IDLE. Mismatch -> err with code 1, back to IDLE, cpu_hold stays 1.
- Write latency: mem_we asserts the cycle after the 6th byte of a line is accepted.
- Timeout: an idle counter runs in COUNT, DATA and CSUM. It resets on every accepted byte. When it reaches TIMEOUT -> err with code 3, back to IDLE. It is held at 0 in IDLE.
- cpu_hold after an error: it stays 1 after any err, including a frame aborted after partial writes. It is cleared only by a done.
- A SYNC_BYTE value inside COUNT/DATA/CSUM is treated as data, never as a resync.
- done and err never assert in the same cycle. Both are registered outputs.

Test Plan:
- Good 2-line frame: send A5 02, then line 0 = {00,40,00,00,00,00} and line 1 = {3C,12,80,18,00,07}, then CSUM = 40^3C^12^80^18^07. Required: mem_we at addr 0 with data 46'h004000000000, then addr 1 with data 46'h3C1280180007; then done; lines_loaded = 2; cpu_hold goes 1 -> 0.
- Bad checksum: same frame with CSUM ^ 8'h01. Required: both writes occur, err with err_code = 1, no done, cpu_hold stays 1, lines_loaded unchanged.
- Count bounds: A5 00 gives err with code 0; A5 11 gives err with code 0; A5 10 followed by 96 line bytes and a correct CSUM gives 16 writes at addrs 0..15 and done.
- Reserved bits and backpressure: byte0 = C0 gives err with code 2 and no mem_we. With in_valid held high across a line, in_ready drops for exactly one cycle after the 6th byte, and no byte is lost.
- Timeout: with TIMEOUT = 20, send A5 01 00 and then idle for 20 cycles. Required: err with code 3 and state IDLE. A following good frame loads normally.
- Reset mid-frame: assert rst after 3 line bytes. Required: all outputs return to reset values. Garbage bytes before a new A5 are ignored. A full good frame then produces done.

Source files
------------

// File: rtl/prog_loader.sv
// Program-memory writer for the MCX core: parses framed byte-stream images into 46-bit lines
// and holds the core in reset until an image loads with a good checksum.
module prog_loader #(
   parameter int unsigned DEPTH         = 16,
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
   parameter int unsigned TIMEOUT       = 1000,
   parameter bit          HOLD_AT_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        mem_we,
   output logic [3:0]  mem_addr,
   output logic [45:0] mem_data,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [4:0]  lines_loaded
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StCount = 3'd1;
   localparam logic [2:0] StData  = 3'd2;
   localparam logic [2:0] StWrite = 3'd3;
   localparam logic [2:0] StCsum  = 3'd4;

   localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [7:0] DEPTH_B = 8'(DEPTH);

   logic [2:0]    state_q, state_d;
   logic [4:0]    n_q, n_d;
   logic [4:0]    line_q, line_d;
   logic [2:0]    byte_q, byte_d;
   logic [7:0]    csum_q, csum_d;
   logic [47:0]   asm_q, asm_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          mem_we_q, mem_we_d;
   logic [3:0]    mem_addr_q, mem_addr_d;
   logic [45:0]   mem_data_q, mem_data_d;
   logic          hold_q, hold_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [1:0]    code_q, code_d;
   logic [4:0]    lines_q, lines_d;
   logic          accept;
   logic          timed;

   assign in_ready = (state_q != StWrite);
   assign accept   = in_valid && in_ready;
   // Idle timer only runs while a frame is waiting on the stream.
   assign timed    = (state_q == StCount) || (state_q == StData) || (state_q == StCsum);

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      line_d     = line_q;
      byte_d     = byte_q;
      csum_d     = csum_q;
      asm_d      = asm_q;
      tmo_d      = tmo_q;
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      hold_d     = hold_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      code_d     = code_q;
      lines_d    = lines_q;

      case (state_q)
         StIdle: begin
            tmo_d = '0;
            if (accept && in_data == SYNC_BYTE) begin
               state_d = StCount;
               hold_d  = 1'b1;
            end
         end
         StCount: begin
            if (accept) begin
               if (in_data == 8'd0 || in_data > DEPTH_B) begin
                  err_d   = 1'b1;
                  code_d  = 2'd0;
                  state_d = StIdle;
               end else begin
                  n_d     = in_data[4:0];
                  line_d  = '0;
                  byte_d  = '0;
                  csum_d  = '0;
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (accept) begin
               asm_d  = {asm_q[39:0], in_data};
               csum_d = csum_q ^ in_data;
               if (byte_q == 3'd0 && in_data[7:6] != 2'b00) begin
                  err_d   = 1'b1;
                  code_d  = 2'd2;
                  state_d = StIdle;
               end else if (byte_q == 3'd5) begin
                  byte_d     = '0;
                  mem_we_d   = 1'b1;
                  mem_addr_d = line_q[3:0];
                  mem_data_d = asm_d[45:0];
                  state_d    = StWrite;
               end else begin
                  byte_d = byte_q + 3'd1;
               end
            end
         end
         StWrite: begin
            tmo_d   = '0;
            line_d  = line_q + 5'd1;
            state_d = (line_d == n_q) ? StCsum : StData;
         end
         StCsum: begin
            if (accept) begin
               state_d = StIdle;
               if (in_data == csum_q) begin
                  done_d  = 1'b1;
                  lines_d = n_q;
                  hold_d  = 1'b0;
               end else begin
                  err_d  = 1'b1;
                  code_d = 2'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (timed) begin
         if (accept) begin
            tmo_d = '0;
         end else if (tmo_q == TMO_LAST) begin
            tmo_d   = '0;
            err_d   = 1'b1;
            code_d  = 2'd3;
            state_d = StIdle;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         n_q        <= '0;
         line_q     <= '0;
         byte_q     <= '0;
         csum_q     <= '0;
         asm_q      <= '0;
         tmo_q      <= '0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         hold_q     <= HOLD_AT_RESET;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         code_q     <= '0;
         lines_q    <= '0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         line_q     <= line_d;
         byte_q     <= byte_d;
         csum_q     <= csum_d;
         asm_q      <= asm_d;
         tmo_q      <= tmo_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
         code_q     <= code_d;
         lines_q    <= lines_d;
      end
   end

   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_data     = mem_data_q;
   assign cpu_hold     = hold_q;
   assign busy         = (state_q != StIdle);
   assign done         = done_q;
   assign err          = err_q;
   assign err_code     = code_q;
   assign lines_loaded = lines_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of frame vectors plus hand sequences for timeout/reset.
module tb_prog_loader;

   localparam int unsigned TMO = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        mem_we;
   logic [3:0]  mem_addr;
   logic [45:0] mem_data;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [4:0]  lines_loaded;

   always #5 clk = ~clk;

   prog_loader #(
      .DEPTH(16),
      .SYNC_BYTE(8'hA5),
      .TIMEOUT(TMO),
      .HOLD_AT_RESET(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_data(mem_data),
      .cpu_hold(cpu_hold),
      .busy(busy),
      .done(done),
      .err(err),
      .err_code(err_code),
      .lines_loaded(lines_loaded)
   );

   typedef struct {
      logic [7:0] cnt;
      logic [7:0] b0;
      logic [7:0] flip;
      int         exp_writes;
      bit         exp_done;
      bit         exp_err;
      logic [1:0] exp_code;
      bit         exp_hold;
      logic [4:0] exp_lines;
   } vec_t;

   vec_t vecs[8];

   int checks = 0;
   int failures = 0;

   int n_done = 0;
   int n_err = 0;
   int n_stall = 0;
   int n_both = 0;
   logic [1:0] last_code = 2'd0;
   logic [3:0] wr_addr[$];
   logic [45:0] wr_data[$];

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data);
         end
         if (done) n_done <= n_done + 1;
         if (err) begin
            n_err <= n_err + 1;
            last_code <= err_code;
         end
         if (done && err) n_both <= n_both + 1;
         if (in_valid && !in_ready) n_stall <= n_stall + 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard;
      in_data = b;
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("ready_wait", 64'(guard < 50), 64'd1);
      @(negedge clk);
   endtask

   function automatic logic [7:0] lb(input int i, input int k, input logic [7:0] b0);
      if (k == 0) return (i == 0) ? b0 : 8'((i * 7) % 64);
      if (i == 0 && k == 2) return 8'hA5;
      return 8'(i * 29 + k * 53 + 1);
   endfunction

   task automatic run_row(input int r, input vec_t v);
      logic [7:0] fr[$];
      logic [7:0] x;
      logic [7:0] b;
      logic [7:0] b0v;
      logic [45:0] ed;
      bit stop;
      int d0, e0, s0;
      string tag;
      tag = $sformatf("row%0d", r);
      d0 = n_done;
      e0 = n_err;
      s0 = n_stall;
      wr_addr.delete();
      wr_data.delete();
      x = 8'h00;
      stop = 1'b0;
      fr.push_back(8'hA5);
      fr.push_back(v.cnt);
      if (!(v.exp_err && v.exp_code == 2'd0)) begin
         for (int i = 0; i < int'(v.cnt) && !stop; i++) begin
            for (int k = 0; k < 6 && !stop; k++) begin
               b = lb(i, k, v.b0);
               fr.push_back(b);
               x = x ^ b;
               if (v.exp_err && v.exp_code == 2'd2 && k == 0) stop = 1'b1;
            end
         end
         if (!stop) fr.push_back(x ^ v.flip);
      end
      foreach (fr[j]) send_byte(fr[j]);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk({tag, "_done"}, 64'(n_done - d0), 64'(v.exp_done));
      chk({tag, "_err"}, 64'(n_err - e0), 64'(v.exp_err));
      if (v.exp_err) chk({tag, "_code"}, 64'(last_code), 64'(v.exp_code));
      chk({tag, "_nwrites"}, 64'(wr_addr.size()), 64'(v.exp_writes));
      for (int j = 0; j < wr_addr.size(); j++) begin
         b0v = lb(j, 0, v.b0);
         ed = {b0v[5:0], lb(j, 1, v.b0), lb(j, 2, v.b0), lb(j, 3, v.b0), lb(j, 4, v.b0),
               lb(j, 5, v.b0)};
         chk($sformatf("%s_addr%0d", tag, j), 64'(wr_addr[j]), 64'(j));
         chk($sformatf("%s_data%0d", tag, j), 64'(wr_data[j]), 64'(ed));
      end
      chk({tag, "_stalls"}, 64'(n_stall - s0), 64'(v.exp_writes));
      chk({tag, "_hold"}, 64'(cpu_hold), 64'(v.exp_hold));
      chk({tag, "_lines"}, 64'(lines_loaded), 64'(v.exp_lines));
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_both"}, 64'(n_both), 64'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "_we"}, 64'(mem_we), 64'd0);
      chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
      chk({tag, "_data"}, 64'(mem_data), 64'd0);
      chk({tag, "_hold"}, 64'(cpu_hold), 64'd1);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
      chk({tag, "_code"}, 64'(err_code), 64'd0);
      chk({tag, "_lines"}, 64'(lines_loaded), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] sp[$];
      int d0, e0, cyc;
      //        cnt    b0     flip   wr  done err code hold lines
      vecs[0] = '{8'h02, 8'h00, 8'h00, 2,  1,   0,  0,   0,   5'd2};
      vecs[1] = '{8'h02, 8'h00, 8'h01, 2,  0,   1,  1,   1,   5'd2};
      vecs[2] = '{8'h00, 8'h00, 8'h00, 0,  0,   1,  0,   1,   5'd2};
      vecs[3] = '{8'h11, 8'h00, 8'h00, 0,  0,   1,  0,   1,   5'd2};
      vecs[4] = '{8'h10, 8'h2A, 8'h00, 16, 1,   0,  0,   0,   5'd16};
      vecs[5] = '{8'h01, 8'hC0, 8'h00, 0,  0,   1,  2,   1,   5'd16};
      vecs[6] = '{8'h03, 8'h40, 8'h00, 0,  0,   1,  2,   1,   5'd16};
      vecs[7] = '{8'h01, 8'h3F, 8'h00, 1,  1,   0,  0,   0,   5'd1};

      rst = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);

      // Reference frame with hand-computed line images and checksum.
      wr_addr.delete();
      wr_data.delete();
      d0 = n_done;
      send_byte(8'hA5);
      chk("ref_hold_during", 64'(cpu_hold), 64'd1);
      chk("ref_busy_during", 64'(busy), 64'd1);
      sp = '{8'h02, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h3C, 8'h12, 8'h80, 8'h18, 8'h00, 8'h07, 8'hF1};
      foreach (sp[j]) send_byte(sp[j]);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("ref_nwrites", 64'(wr_addr.size()), 64'd2);
      if (wr_addr.size() == 2) begin
         chk("ref_addr0", 64'(wr_addr[0]), 64'd0);
         chk("ref_data0", 64'(wr_data[0]), 64'h004000000000);
         chk("ref_addr1", 64'(wr_addr[1]), 64'd1);
         chk("ref_data1", 64'(wr_data[1]), 64'h3C1280180007);
      end
      chk("ref_done", 64'(n_done - d0), 64'd1);
      chk("ref_lines", 64'(lines_loaded), 64'd2);
      chk("ref_hold_after", 64'(cpu_hold), 64'd0);

      for (int r = 0; r < 8; r++) run_row(r, vecs[r]);

      // Timeout: stall mid-line and expect abort after TMO idle cycles.
      e0 = n_err;
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      in_valid = 1'b0;
      cyc = 0;
      while (n_err == e0 && cyc < 3 * TMO) begin
         @(negedge clk);
         cyc++;
      end
      chk("tmo_err", 64'(n_err - e0), 64'd1);
      chk("tmo_code", 64'(last_code), 64'd3);
      chk("tmo_window", 64'(cyc >= TMO - 1 && cyc <= TMO + 2), 64'd1);
      @(negedge clk);
      chk("tmo_busy", 64'(busy), 64'd0);
      chk("tmo_hold", 64'(cpu_hold), 64'd1);
      run_row(100, vecs[7]);

      // Reset in the middle of a line.
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals("midrst");
      rst = 1'b0;
      @(negedge clk);
      e0 = n_err;
      d0 = n_done;
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h00);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("garbage_busy", 64'(busy), 64'd0);
      chk("garbage_quiet", 64'((n_err - e0) + (n_done - d0)), 64'd0);
      run_row(101, vecs[7]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
